// File: rtl/mem_pkg.sv
// Memory command encoding and arbiter types shared by the CPU controller and
// the RAM port arbiter.
package mem_pkg;

    typedef logic [1:0] mem_cmd_t;

    localparam mem_cmd_t MNONE  = 2'b00;
    localparam mem_cmd_t MREAD  = 2'b01;
    localparam mem_cmd_t MWRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ACK
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    // 2'b11 is reserved and behaves like MNONE.
    function automatic logic is_req(input mem_cmd_t cmd);
        return (cmd == MREAD) || (cmd == MWRITE);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// One master's request/acknowledge bus into the RAM port arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    mem_pkg::mem_cmd_t  cmd;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic               ack;
    logic [DATA_W-1:0]  rdata;

    modport master (output cmd, addr, wdata, input ack, rdata);
    modport slave  (input cmd, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_port_arbiter_rr.sv
// Two-way round-robin picker: bit 0 is the CPU, bit 1 the DMA port.
// On a tie the master that was not granted last wins.
module rr_arbiter2
    import mem_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_t     last_grant_i,
    output logic [1:0] grant_o
);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_grant_i == OWN_CPU) ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port RAM between the CPU and DMA masters, one transaction
// at a time, with registered RAM command outputs and a one-cycle ack pulse.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave cpu,
    mem_port_arbiter_if.slave dma,
    output mem_cmd_t          ram_cmd_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              busy_o
);

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_grant_q, last_grant_d;
    logic [2:0]        cnt_q, cnt_d;
    mem_cmd_t          ram_cmd_q, ram_cmd_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;

    logic [1:0]        req;
    logic [1:0]        grant;
    logic              go_ack;

    assign req = {is_req(dma.cmd), is_req(cpu.cmd)};

    rr_arbiter2 u_rr (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    // NOTE: sequential state uses non-blocking assignments only; rst is synchronous, so it is tested inside the clocked branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_CPU;
            last_grant_q <= OWN_DMA;
            cnt_q        <= '0;
            ram_cmd_q    <= MNONE;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            rdata_q      <= '0;
            cpu_ack_q    <= 1'b0;
            dma_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            ram_cmd_q    <= ram_cmd_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            rdata_q      <= rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            dma_ack_q    <= dma_ack_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        ram_cmd_d    = ram_cmd_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        rdata_d      = rdata_q;
        go_ack       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ram_cmd_d = MNONE;
                if (grant[0]) begin
                    owner_d      = OWN_CPU;
                    last_grant_d = OWN_CPU;
                    ram_cmd_d    = cpu.cmd;
                    ram_addr_d   = cpu.addr;
                    ram_wdata_d  = cpu.wdata;
                    state_d      = ST_ISSUE;
                end else if (grant[1]) begin
                    owner_d      = OWN_DMA;
                    last_grant_d = OWN_DMA;
                    ram_cmd_d    = dma.cmd;
                    ram_addr_d   = dma.addr;
                    ram_wdata_d  = dma.wdata;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ram_cmd_q == MWRITE) begin
                    ram_cmd_d = MNONE;
                    go_ack    = 1'b1;
                    state_d   = ST_ACK;
                end else begin
                    cnt_d   = LAT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // RAM data is valid in the cycle the counter shows 1.
                if (cnt_q == 3'd1) begin
                    rdata_d   = ram_rdata_i;
                    ram_cmd_d = MNONE;
                    go_ack    = 1'b1;
                    state_d   = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                ram_cmd_d = MNONE;
                state_d   = ST_IDLE;
            end
        endcase

        cpu_ack_d = go_ack && (owner_q == OWN_CPU);
        dma_ack_d = go_ack && (owner_q == OWN_DMA);
    end

    always_comb begin
        busy_o      = (state_q != ST_IDLE);
        ram_cmd_o   = ram_cmd_q;
        ram_addr_o  = ram_addr_q;
        ram_wdata_o = ram_wdata_q;
        cpu.ack     = cpu_ack_q;
        dma.ack     = dma_ack_q;
        cpu.rdata   = rdata_q;
        dma.rdata   = rdata_q;
    end

endmodule
